pll_reset_ctrl: RTL



---
 rtl/odo_clk_pkg.sv | 29 ++
 rtl/bit_sync.sv | 31 +++
 rtl/pll_reset_ctrl.sv | 124 ++++++++++++
 3 files changed

// File: rtl/odo_clk_pkg.sv
// ---------------------------------------------------------------------------
// odo_clk_pkg
// Shared types for the PLL reset/lock supervisor.
//   pll_state_e : supervisor states (PLL_RESET, WAIT_LOCK, STABLE, RUN)
//   cnt_width() : width of the shared cycle counter, which must reach the
//                 largest of the three cycle parameters minus one
// ---------------------------------------------------------------------------
package odo_clk_pkg;

    typedef enum logic [1:0] {
        PLL_RESET = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_e;

    // Counter only ever has to hold (max-1), so clog2(max) bits suffice;
    // clamp to one bit when every parameter is 1.
    function automatic int unsigned cnt_width(input int unsigned a,
                                              input int unsigned b,
                                              input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return (m <= 1) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/bit_sync.sv
// ---------------------------------------------------------------------------
// bit_sync
// Two-flop synchronizer for a single asynchronous level, reset to 0.
//   clk_i : destination clock
//   rst_i : asynchronous active-high reset
//   d_i   : asynchronous input level
//   q_o   : synchronized level (two destination edges of latency)
// ---------------------------------------------------------------------------
module bit_sync (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/pll_reset_ctrl.sv
// ---------------------------------------------------------------------------
// pll_reset_ctrl
// Reset and lock supervisor for the board PLL. Pulses the PLL reset, waits
// for a stable synchronized lock, then releases the core. Lock loss or lock
// timeout re-pulses the PLL reset and bumps a saturating recovery counter.
//   clk          : free-running board reference clock
//   rst          : asynchronous active-high reset
//   pll_locked   : PLL lock indication (asynchronous)
//   sw_relock    : single-cycle request to force a PLL re-reset
//   pll_rst      : PLL reset output
//   core_rst     : core reset (asserted asynchronously by rst)
//   ready        : high only while running
//   relock_count : saturating count of automatic recoveries
// ---------------------------------------------------------------------------
module pll_reset_ctrl
    import odo_clk_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_STABLE_CYCLES  = 5000,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 50000,
    parameter int unsigned CNT_W               = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pll_locked,
    input  logic             sw_relock,
    output logic             pll_rst,
    output logic             core_rst,
    output logic             ready,
    output logic [CNT_W-1:0] relock_count
);

    localparam int unsigned CW = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES,
                                           LOCK_TIMEOUT_CYCLES);

    localparam logic [CW-1:0] PR_LAST = CW'(PLL_RST_CYCLES - 1);
    localparam logic [CW-1:0] ST_LAST = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST = CW'(LOCK_TIMEOUT_CYCLES - 1);

    pll_state_e       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [CNT_W-1:0] relock_q, relock_d;
    logic             pll_rst_q, core_rst_q, ready_q;
    logic             restart;
    logic             bump;
    logic             locked_s;

    bit_sync u_lock_sync (
        .clk_i (clk),
        .rst_i (rst),
        .d_i   (pll_locked),
        .q_o   (locked_s)
    );

    always_comb begin
        state_d  = state_q;
        restart  = 1'b0;
        bump     = 1'b0;
        cnt_d    = cnt_q;
        relock_d = relock_q;

        if (sw_relock) begin
            // Also taken from PLL_RESET, where it must restart the pulse.
            state_d = PLL_RESET;
            restart = 1'b1;
        end else begin
            case (state_q)
                PLL_RESET: begin
                    if (cnt_q == PR_LAST) state_d = WAIT_LOCK;
                end
                WAIT_LOCK: begin
                    if (locked_s) begin
                        state_d = STABLE;
                    end else if (cnt_q == TO_LAST) begin
                        state_d = PLL_RESET;
                        bump    = 1'b1;
                    end
                end
                STABLE: begin
                    if (!locked_s)            state_d = WAIT_LOCK;
                    else if (cnt_q == ST_LAST) state_d = RUN;
                end
                RUN: begin
                    if (!locked_s) begin
                        state_d = PLL_RESET;
                        bump    = 1'b1;
                    end
                end
                default: state_d = PLL_RESET;
            endcase
        end

        // Counter is idle in RUN so it cannot wrap during long runs.
        if (restart || (state_d != state_q)) cnt_d = '0;
        else if (state_q != RUN)             cnt_d = cnt_q + CW'(1);

        if (bump && (relock_q != '1)) relock_d = relock_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= PLL_RESET;
            cnt_q      <= '0;
            relock_q   <= '0;
            pll_rst_q  <= 1'b1;
            core_rst_q <= 1'b1;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            relock_q   <= relock_d;
            // Decoded from the next state so outputs move with the state.
            pll_rst_q  <= (state_d == PLL_RESET);
            core_rst_q <= (state_d != RUN);
            ready_q    <= (state_d == RUN);
        end
    end

    assign pll_rst      = pll_rst_q;
    assign core_rst     = core_rst_q;
    assign ready        = ready_q;
    assign relock_count = relock_q;

endmodule
